// File: rtl/fetch_stage_if.sv
// Bundles the run/redirect controls, the instruction-memory req/ack bus and the
// IF/ID valid/ready bus. "master" is the fetch stage; "slave" is memory + decode.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  trigger;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  id_valid;
  logic                  id_ready;
  logic [DATA_WIDTH-1:0] id_instr;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [ADDR_WIDTH-1:0] id_pcplus4;
  logic                  misaligned;

  modport master (
    input  trigger, redirect, redirect_target, imem_ack, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pcplus4, misaligned
  );

  modport slave (
    output trigger, redirect, redirect_target, imem_ack, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pcplus4, misaligned
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a variable-latency imem
// req/ack bus and feeds decode through an IF/ID register with a one-entry skid.
module fetch_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic           CLK,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN, S_HALT} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                  r_req, w_req_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                  r_id_valid, w_id_valid_nxt;
  logic [DATA_WIDTH-1:0] r_id_instr, w_id_instr_nxt;
  logic [ADDR_WIDTH-1:0] r_id_pc, w_id_pc_nxt;
  logic [DATA_WIDTH-1:0] r_skid_instr, w_skid_instr_nxt;
  logic [ADDR_WIDTH-1:0] r_skid_pc, w_skid_pc_nxt;
  logic                  r_mis, w_mis_nxt;

  logic                  w_ack, w_pending, w_slot_free, w_redir, w_tgt_mis;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;

  // r_req is only ever high in FETCH/DRAIN, so it qualifies acks on its own
  assign w_ack       = r_req & bus.imem_ack;
  assign w_pending   = r_req & ~bus.imem_ack;
  assign w_slot_free = ~r_id_valid | bus.id_ready;
  assign w_redir     = bus.redirect & ~r_mis;
  assign w_tgt_mis   = (bus.redirect_target[1:0] != 2'b00);
  assign w_pc_plus4  = r_pc + ADDR_WIDTH'(4);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_nxt        = r_req;
    w_addr_nxt       = r_addr;
    w_id_valid_nxt   = r_id_valid & ~bus.id_ready;
    w_id_instr_nxt   = r_id_instr;
    w_id_pc_nxt      = r_id_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_mis_nxt        = r_mis;

    case (r_state)
      S_IDLE: begin
        if (bus.trigger) begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_pc;
        end
      end
      S_FETCH: begin
        if (w_ack) begin
          w_pc_nxt   = w_pc_plus4;
          w_addr_nxt = w_pc_plus4;
          if (w_slot_free) begin
            w_id_valid_nxt = 1'b1;
            w_id_instr_nxt = bus.imem_rdata;
            w_id_pc_nxt    = r_pc;
            if (!bus.trigger) begin
              w_state_nxt = S_IDLE;
              w_req_nxt   = 1'b0;
            end
          end else begin
            w_skid_instr_nxt = bus.imem_rdata;
            w_skid_pc_nxt    = r_pc;
            w_req_nxt        = 1'b0;
            w_state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.id_ready) begin
          w_id_valid_nxt = 1'b1;
          w_id_instr_nxt = r_skid_instr;
          w_id_pc_nxt    = r_skid_pc;
          w_state_nxt    = bus.trigger ? S_FETCH : S_IDLE;
          w_req_nxt      = bus.trigger;
          w_addr_nxt     = r_pc;
        end
      end
      S_DRAIN: begin
        if (w_ack) begin
          w_addr_nxt = r_pc;
          if (r_mis) begin
            w_state_nxt = S_HALT;
            w_req_nxt   = 1'b0;
          end else begin
            w_state_nxt = bus.trigger ? S_FETCH : S_IDLE;
            w_req_nxt   = bus.trigger;
          end
        end
      end
      default: begin
        w_req_nxt = 1'b0;
      end
    endcase

    // Redirect overrides everything above. An outstanding request is never
    // withdrawn: it is drained first and its data dropped. A redirect that
    // coincides with the draining ack already counts as drained.
    if (w_redir) begin
      w_id_valid_nxt = 1'b0;
      if (w_tgt_mis) begin
        w_mis_nxt = 1'b1;
        w_pc_nxt  = r_pc;
        if (w_pending) begin
          w_state_nxt = S_DRAIN;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_addr;
        end else begin
          w_state_nxt = S_HALT;
          w_req_nxt   = 1'b0;
          w_addr_nxt  = r_addr;
        end
      end else begin
        w_pc_nxt = bus.redirect_target;
        if (w_pending) begin
          w_state_nxt = S_DRAIN;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_addr;
        end else begin
          w_state_nxt = bus.trigger ? S_FETCH : S_IDLE;
          w_req_nxt   = bus.trigger;
          w_addr_nxt  = bus.redirect_target;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VECTOR;
      r_req        <= 1'b0;
      r_addr       <= RESET_VECTOR;
      r_id_valid   <= 1'b0;
      r_id_instr   <= '0;
      r_id_pc      <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_mis        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_id_pc      <= w_id_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_mis        <= w_mis_nxt;
    end
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_addr;
  assign bus.id_valid   = r_id_valid;
  assign bus.id_instr   = r_id_instr;
  assign bus.id_pc      = r_id_pc;
  assign bus.id_pcplus4 = r_id_pc + ADDR_WIDTH'(4);
  assign bus.misaligned = r_mis;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Parametrised instruction-fetch front end for the next-generation (pipelined) core.
- Replaces the single-cycle PC/instruction-memory path: owns the PC and drives a variable-latency instruction-memory req/ack interface.
- Presents fetched instructions to decode through a valid/ready IF/ID register with a one-entry skid buffer.
- Handles stall, branch/jump redirect with flush, and misaligned-target trapping.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC/address width.
- RESET_VECTOR, 0, PC value after reset; must have bits [1:0] = 0.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- trigger  input  1  run enable; when low, no new fetch is issued.
- redirect  input  1  taken branch/jump resolved downstream; flushes fetch.
- redirect_target  input  ADDR_WIDTH  new PC when redirect=1.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  ADDR_WIDTH  fetch address, registered, equals pc.
- imem_ack  input  1  memory response valid; may arrive in the same cycle as imem_req or later.
- imem_rdata  input  DATA_WIDTH  instruction word, valid when imem_ack=1.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_ready  input  1  decode accepts the instruction this cycle; low means stall.
- id_instr  output  DATA_WIDTH  fetched instruction.
- id_pc  output  ADDR_WIDTH  address of id_instr.
- id_pcplus4  output  ADDR_WIDTH  id_pc+4, modulo 2^ADDR_WIDTH.
- misaligned  output  1  sticky error: redirect target with [1:0] != 0.

Behaviour:
- Clock and reset: one clock, CLK; reset rst is synchronous and active-high.
- On reset: pc=RESET_VECTOR, state=IDLE, imem_req=0, imem_addr=RESET_VECTOR, id_valid=0, id_instr=0, id_pc=0, id_pcplus4=4, skid empty, misaligned=0. Reset mid-request abandons the request and ignores any later ack.
- States: IDLE, FETCH, HOLD, DRAIN, HALT.
- IDLE: if trigger=1, go to FETCH next cycle with imem_req=1 and imem_addr=pc.
- FETCH: imem_req and imem_addr are held stable until imem_ack=1; a request is never withdrawn.
- FETCH, ack cycle, slot free (id_valid=0 or id_ready=1):
  - load id_instr=imem_rdata, id_pc=pc, id_valid=1; pc<=pc+4.
  - trigger=1: stay FETCH with imem_addr=pc+4, giving 1 instr/cycle with zero-wait memory.
  - trigger=0: go IDLE with imem_req=0.
- FETCH, ack cycle, slot occupied and id_ready=0: capture the word and pc into the skid buffer; pc<=pc+4; imem_req=0; go HOLD.
- HOLD: when id_ready=1, move skid to IF/ID (id_valid stays 1), empty the skid, then go FETCH if trigger=1, else IDLE.
- id_valid drops to 0 after a handshake (id_valid & id_ready) when no new word is loaded in the same cycle.
- Redirect has highest priority over all of the above:
  - next cycle: id_valid=0, skid emptied, pc<=redirect_target.
  - FETCH without ack in the redirect cycle: go DRAIN, keeping imem_req=1 at the old address.
  - DRAIN: on ack, discard the data, then go FETCH at the new pc (IDLE if trigger=0).
  - FETCH with ack in the redirect cycle: discard the data, go FETCH at the target.
  - IDLE or HOLD: go FETCH at the target (IDLE if trigger=0).
  - redirect during DRAIN: update pc only, remain in DRAIN.
- Misaligned redirect (redirect_target[1:0] != 0):
  - misaligned<=1, id_valid=0, go HALT; any outstanding request is drained first, data discarded.
  - HALT: imem_req=0, outputs frozen; only rst exits.
- Arithmetic: pc+4 and id_pcplus4 wrap modulo 2^ADDR_WIDTH; no overflow flag.
- id_instr, id_pc and id_pcplus4 are don't-care while id_valid=0, but must not change while id_valid=1 and id_ready=0.

Test Plan:
- Reset, trigger=1, imem_ack tied 1 with rdata=addr^0xA5A5A5A5 -> imem_addr 0,4,8,… on consecutive cycles; id_pc follows one cycle later; id_valid=1 continuously from cycle 2.
- Ack delayed 3 cycles per request -> imem_addr held 3 cycles; id_valid pulses one cycle per word; no duplicated or lost PCs.
- id_ready=0 for 4 cycles mid-stream -> id_instr/id_pc frozen; skid captures the next word; imem_req=0 in HOLD; sequence resumes without gap or loss when id_ready=1.
- redirect=1, target=0x100, during a 3-cycle wait at 0x20 -> id_valid=0 next cycle; imem_addr stays 0x20 until ack (DRAIN); that data is never presented; next fetch at 0x100.
- redirect with target=0x102 -> misaligned=1 and sticky; imem_req=0; id_valid=0 until rst; after rst, misaligned=0 and fetch restarts at RESET_VECTOR.
- RESET_VECTOR=0xFFFFFFF8, zero-wait memory -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; id_pcplus4=0 for id_pc=0xFFFFFFFC.
